// File: rtl/key_schedule_seq_128.sv
// Iterative AES-128 key-schedule sequencer: one external expander pass per round, 11 round keys held in a register file.
// Latency: keys_valid rises 10*(EK_LATENCY+1) cycles after the accept edge; key_ready is low for the whole expansion.
module key_schedule_seq_128 #(
    parameter int EK_LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic [127:0] ek_in,
    output logic [7:0]   ek_rcon,
    input  logic [127:0] ek_out,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_data,
    output logic         keys_valid,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_MAX    = 4'(EK_LATENCY);
    localparam logic [3:0] LAST_ROUND = 4'd10;

    state_t       state, state_nxt;
    logic [127:0] rk [0:10];
    logic [3:0]   round;
    logic [3:0]   cnt;
    logic [7:0]   rcon;
    logic         accept;
    logic         round_end;
    logic [3:0]   prev_idx;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        key_ready = (state != RUN);
        busy      = (state == RUN);
        accept    = key_valid && (state != RUN);
        round_end = (state == RUN) && (cnt == CNT_MAX);
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (round_end && round == LAST_ROUND) state_nxt = DONE;
            DONE:    if (accept) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= 10; i++) rk[i] <= '0;
            round      <= '0;
            cnt        <= '0;
            rcon       <= 8'h01;
            keys_valid <= 1'b0;
        end else if (accept) begin
            rk[0]      <= key_in;
            round      <= 4'd1;
            cnt        <= '0;
            rcon       <= 8'h01;
            keys_valid <= 1'b0;
        end else if (round_end) begin
            for (int i = 1; i <= 10; i++) begin
                if (round == 4'(i)) rk[i] <= ek_out;
            end
            cnt  <= '0;
            rcon <= xtime(rcon);
            if (round == LAST_ROUND) keys_valid <= 1'b1;
            else                     round      <= round + 4'd1;
        end else if (state == RUN) begin
            cnt <= cnt + 4'd1;
        end
    end

    // round never passes 10, so round-1 is already saturated outside RUN
    assign prev_idx = (round == 4'd0) ? 4'd0 : round - 4'd1;
    assign ek_rcon  = rcon;

    always_comb begin
        ek_in   = '0;
        rk_data = '0;
        for (int i = 0; i <= 10; i++) begin
            if (prev_idx == 4'(i)) ek_in   = rk[i];
            if (rk_idx == 4'(i))   rk_data = rk[i];
        end
    end

endmodule

// File: tb/tb_key_schedule_seq_128.sv
// Randomized bench for key_schedule_seq_128 with a behavioural expander stand-in and a FIPS-197 word-level reference schedule.
module tb_key_schedule_seq_128;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key_in = '0;
    logic [127:0] ek_in;
    logic [7:0]   ek_rcon;
    logic [127:0] ek_out;
    logic [3:0]   rk_idx = '0;
    logic [127:0] rk_data;
    logic         keys_valid;
    logic         busy;

    logic         key_valid3 = 1'b0;
    logic         key_ready3;
    logic [127:0] key_in3 = '0;
    logic [127:0] ek_in3;
    logic [7:0]   ek_rcon3;
    logic [127:0] ek_out3;
    logic [3:0]   rk_idx3 = '0;
    logic [127:0] rk_data3;
    logic         keys_valid3;
    logic         busy3;

    int n_checks = 0;
    int n_errors = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    key_schedule_seq_128 u_dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
        .key_in(key_in), .ek_in(ek_in), .ek_rcon(ek_rcon), .ek_out(ek_out),
        .rk_idx(rk_idx), .rk_data(rk_data), .keys_valid(keys_valid), .busy(busy)
    );

    key_schedule_seq_128 #(.EK_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid3), .key_ready(key_ready3),
        .key_in(key_in3), .ek_in(ek_in3), .ek_rcon(ek_rcon3), .ek_out(ek_out3),
        .rk_idx(rk_idx3), .rk_data(rk_data3), .keys_valid(keys_valid3), .busy(busy3)
    );

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // multiplicative inverse as a^254, then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] p;
        inv = 8'h01;
        p   = a;
        for (int i = 1; i < 8; i++) begin
            p   = gmul(p, p);
            inv = gmul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] exp_round(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // 44-word FIPS-197 expansion, returns round key k
    function automatic logic [127:0] model_rk(input logic [127:0] key, input int k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endfunction

    // ---------------- expander stand-ins (no reset, pure pipelines) ----------------
    logic [127:0] p1, q1, q2;
    always @(posedge clk) begin
        p1     <= exp_round(ek_in, ek_rcon);
        ek_out <= p1;
    end
    always @(posedge clk) begin
        q1      <= exp_round(ek_in3, ek_rcon3);
        q2      <= q1;
        ek_out3 <= q2;
    end

    // ---------------- behavioural model of the sequencer ----------------
    localparam int L = 2;
    logic [7:0]   rcon_tab [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    int           m_phase = 0;   // 0 idle, 1 expanding, 2 done
    int           m_t = 0;
    int           m_round = 0;
    logic         m_kv = 1'b0;
    logic [127:0] m_rk    [0:10];
    logic [127:0] m_sched [0:10];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_t = 0; m_round = 0; m_kv = 1'b0;
            for (int k = 0; k <= 10; k++) m_rk[k] = '0;
        end else if (m_phase != 1 && key_valid) begin
            for (int k = 0; k <= 10; k++) m_sched[k] = model_rk(key_in, k);
            m_rk[0] = key_in;
            m_phase = 1; m_t = 0; m_round = 1; m_kv = 1'b0;
        end else if (m_phase == 1) begin
            m_t++;
            if (m_t % (L + 1) == 0) begin
                m_rk[m_round] = m_sched[m_round];
                if (m_round == 10) begin
                    m_phase = 2;
                    m_kv    = 1'b1;
                end else begin
                    m_round++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("key_ready", 128'(key_ready), 128'(m_phase != 1));
            chk("busy", 128'(busy), 128'(m_phase == 1));
            chk("keys_valid", 128'(keys_valid), 128'(m_kv));
            chk("rk_data", rk_data, (rk_idx <= 4'd10) ? m_rk[int'(rk_idx)] : 128'h0);
            if (m_phase == 1) begin
                chk("ek_in", ek_in, m_rk[m_round-1]);
                chk("ek_rcon", 128'(ek_rcon), 128'(rcon_tab[m_round]));
            end else if (m_phase == 0) begin
                chk("ek_in_idle", ek_in, 128'h0);
                chk("ek_rcon_idle", 128'(ek_rcon), 128'h01);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        rk_idx = 4'($urandom_range(0, 15));
    endtask

    task automatic read_rk(input int idx, output logic [127:0] d);
        rk_idx = 4'(idx);
        #1;
        d = rk_data;
    endtask

    task automatic accept_key(input logic [127:0] k);
        key_valid = 1'b1;
        key_in    = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic wait_kv(input int start_n, input int expect_n, input string name);
        int n;
        n = start_n;
        while (!keys_valid && n < 200) begin
            tick();
            n++;
        end
        chk(name, 128'(n), 128'(expect_n));
    endtask

    task automatic check_all(input logic [127:0] key, input string name);
        logic [127:0] d;
        for (int k = 0; k <= 10; k++) begin
            read_rk(k, d);
            chk(name, d, model_rk(key, k));
        end
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        logic [127:0] d, ka, kb;
        int n;

        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_key_ready", 128'(key_ready), 128'h1);
        chk("reset_keys_valid", 128'(keys_valid), 128'h0);
        chk("reset_busy", 128'(busy), 128'h0);
        chk("reset_ek_rcon", 128'(ek_rcon), 128'h01);
        chk("reset_ek_in", ek_in, 128'h0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        tick();

        // model pinned to known FIPS-197 / all-zero-key values
        chk("model_fips_rk1", model_rk(FIPS_KEY, 1), 128'ha0fafe1788542cb123a339392a6c7605);
        chk("model_fips_rk10", model_rk(FIPS_KEY, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("model_zero_rk10", model_rk(128'h0, 10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // FIPS key, latency and two literal round keys
        accept_key(FIPS_KEY);
        wait_kv(0, 30, "fips_latency");
        read_rk(1, d);
        chk("fips_rk1", d, 128'ha0fafe1788542cb123a339392a6c7605);
        read_rk(10, d);
        chk("fips_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        for (int i = 11; i <= 15; i++) begin
            read_rk(i, d);
            chk("rk_idx_oob", d, 128'h0);
        end
        tick();

        // competing key held during expansion must be ignored
        ka = {$urandom, $urandom, $urandom, $urandom};
        accept_key(ka);
        key_valid = 1'b1;
        key_in    = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_key_ready", 128'(key_ready), 128'h0);
        end
        key_valid = 1'b0;
        wait_kv(20, 30, "hold_latency");
        check_all(ka, "hold_sched");

        // back-to-back: all-zero key accepted in the first DONE cycle
        key_valid = 1'b1;
        key_in    = 128'h0;
        tick();
        key_valid = 1'b0;
        chk("b2b_kv_drop", 128'(keys_valid), 128'h0);
        wait_kv(0, 30, "b2b_latency");
        read_rk(10, d);
        chk("zero_rk10", d, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        tick();

        // asynchronous reset during round 5
        kb = {$urandom, $urandom, $urandom, $urandom};
        accept_key(kb);
        repeat (13) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_key_ready", 128'(key_ready), 128'h1);
        chk("arst_keys_valid", 128'(keys_valid), 128'h0);
        chk("arst_busy", 128'(busy), 128'h0);
        for (int k = 0; k <= 10; k++) begin
            read_rk(k, d);
            chk("arst_rk_zero", d, 128'h0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        kb = {$urandom, $urandom, $urandom, $urandom};
        accept_key(kb);
        wait_kv(0, 30, "post_rst_latency");
        check_all(kb, "post_rst_sched");

        // random keys with random idle gaps
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 3)) tick();
            ka = {$urandom, $urandom, $urandom, $urandom};
            accept_key(ka);
            wait_kv(0, 30, "rand_latency");
            check_all(ka, "rand_sched");
        end

        // EK_LATENCY=3 build
        key_valid3 = 1'b1;
        key_in3    = FIPS_KEY;
        tick();
        key_valid3 = 1'b0;
        n = 0;
        while (!keys_valid3 && n < 200) begin
            tick();
            n++;
        end
        chk("lat3_latency", 128'(n), 128'd40);
        for (int k = 0; k <= 10; k++) begin
            rk_idx3 = 4'(k);
            #1;
            chk("lat3_sched", rk_data3, model_rk(FIPS_KEY, k));
        end

        tick();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
